// File: rtl/wb_ic_pkg.sv
// rtl/wb_ic_pkg.sv - shared types and address helpers for the shared-bus interconnect
package wb_ic_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int MAX_S  = 16;
    localparam int MAX_AW = 64;

    function automatic logic [3:0] onehot2idx(input logic [MAX_S-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_S; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

    // Windows are compared as an offset from the base so base+size may wrap safely.
    function automatic logic [MAX_S-1:0] addr_decode(
        input logic [MAX_AW-1:0]       adr,
        input logic [MAX_S*MAX_AW-1:0] base_addr,
        input logic [MAX_S*MAX_AW-1:0] size,
        input int                      n
    );
        logic [MAX_S-1:0]  ss;
        logic [MAX_AW-1:0] b;
        logic [MAX_AW-1:0] s;
        ss = '0;
        for (int i = 0; i < MAX_S; i++) begin
            b = base_addr[i*MAX_AW +: MAX_AW];
            s = size[i*MAX_AW +: MAX_AW];
            if (i < n && adr >= b && (adr - b) < s) ss[i] = 1'b1;
        end
        return ss;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin pointer and grant register for the shared bus
module wb_rr_arbiter #(
    parameter  int numm = 2,
    localparam int MW   = (numm > 1) ? $clog2(numm) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [numm-1:0] req,
    input  logic            lock,
    output logic [MW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [MW-1:0] gnt_idx_q;
    logic [MW-1:0] last_idx_q;
    logic [MW-1:0] win;

    always_comb begin
        int  j;
        logic found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= numm; k++) begin
            j = int'(last_idx_q) + k;
            if (j >= numm) j = j - numm;
            if (!found && req[j]) begin
                win   = MW'(j);
                found = 1'b1;
            end
        end
    end

    assign gnt_vld = |req;
    assign gnt_idx = gnt_idx_q;

    // The pointer moves to the winner at grant time, so the next search starts after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx_q  <= '0;
            last_idx_q <= MW'(numm - 1);
        end else if (!lock && gnt_vld) begin
            gnt_idx_q  <= win;
            last_idx_q <= win;
        end
    end

endmodule

// File: rtl/wb_interconnect_sharedbus_rr.sv
// rtl/wb_interconnect_sharedbus_rr.sv - Wishbone pipelined shared bus with round-robin bus lock
module wb_interconnect_sharedbus_rr
    import wb_ic_pkg::*;
#(
    parameter int               numm      = 2,
    parameter int               nums      = 2,
    parameter int               aw        = 32,
    parameter int               dw        = 32,
    parameter int               max_outst = 4,
    parameter logic [nums*aw-1:0] base_addr = '0,
    parameter logic [nums*aw-1:0] size      = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [numm-1:0]        wbm_cyc_i,
    input  logic [numm-1:0]        wbm_stb_i,
    input  logic [numm-1:0]        wbm_we_i,
    input  logic [numm*aw-1:0]     wbm_adr_i,
    input  logic [numm*dw/8-1:0]   wbm_sel_i,
    input  logic [numm*dw-1:0]     wbm_dat_i,
    output logic [numm*dw-1:0]     wbm_dat_o,
    output logic [numm-1:0]        wbm_ack_o,
    output logic [numm-1:0]        wbm_err_o,
    output logic [numm-1:0]        wbm_stall_o,
    output logic [nums-1:0]        wbs_cyc_o,
    output logic [nums-1:0]        wbs_stb_o,
    output logic [nums-1:0]        wbs_we_o,
    output logic [nums*aw-1:0]     wbs_adr_o,
    output logic [nums*dw/8-1:0]   wbs_sel_o,
    output logic [nums*dw-1:0]     wbs_dat_o,
    input  logic [nums*dw-1:0]     wbs_dat_i,
    input  logic [nums-1:0]        wbs_ack_i,
    input  logic [nums-1:0]        wbs_err_i,
    input  logic [nums-1:0]        wbs_stall_i
);

    localparam int MW   = (numm > 1) ? $clog2(numm) : 1;
    localparam int SW   = (nums > 1) ? $clog2(nums) : 1;
    localparam int CW   = $clog2(max_outst + 1);
    localparam int SELW = dw / 8;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   cur_s_q, cur_s_d;
    logic            err_pend_q, err_pend_d;
    logic [MW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic            busy;

    logic                    m_cyc, m_stb, m_we;
    logic [aw-1:0]           m_adr;
    logic [SELW-1:0]         m_sel;
    logic [dw-1:0]           m_dat;
    logic [MAX_S*MAX_AW-1:0] base_w, size_w;
    logic [MAX_S-1:0]        ss_full;
    logic [nums-1:0]         ss, cur_oh;
    logic [SW-1:0]           sel_s;
    logic                    hit, cnt_nz, blocked, m_stall, accept, s_ack, s_err, resp;

    assign busy = (state_q == BUSY);

    wb_rr_arbiter #(.numm(numm)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wbm_cyc_i),
        .lock    (busy),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign m_cyc = wbm_cyc_i[gnt_idx];
    assign m_stb = wbm_stb_i[gnt_idx];
    assign m_we  = wbm_we_i[gnt_idx];
    assign m_adr = wbm_adr_i[int'(gnt_idx)*aw +: aw];
    assign m_sel = wbm_sel_i[int'(gnt_idx)*SELW +: SELW];
    assign m_dat = wbm_dat_i[int'(gnt_idx)*dw +: dw];

    always_comb begin
        base_w = '0;
        size_w = '0;
        for (int i = 0; i < nums; i++) begin
            base_w[i*MAX_AW +: MAX_AW] = MAX_AW'(base_addr[i*aw +: aw]);
            size_w[i*MAX_AW +: MAX_AW] = MAX_AW'(size[i*aw +: aw]);
        end
        cur_oh          = '0;
        cur_oh[cur_s_q] = 1'b1;
    end

    assign ss_full = addr_decode(MAX_AW'(m_adr), base_w, size_w, nums);
    assign ss      = ss_full[nums-1:0];
    assign hit     = |ss;
    assign sel_s   = SW'(onehot2idx(ss_full));
    assign cnt_nz  = (cnt_q != '0);

    // A pending unmapped error also blocks, so it never shares a cycle with a slave response.
    assign blocked = (cnt_q == CW'(max_outst)) | err_pend_q | (cnt_nz & (!hit | (ss != cur_oh)));
    assign m_stall = blocked | (hit & wbs_stall_i[sel_s]);
    assign accept  = busy & m_cyc & m_stb & !m_stall;
    assign s_ack   = wbs_ack_i[cur_s_q] & cnt_nz;
    assign s_err   = wbs_err_i[cur_s_q] & cnt_nz;
    assign resp    = busy & m_cyc & (s_ack | s_err | err_pend_q);

    always_comb begin
        wbm_stall_o = '1;
        wbm_ack_o   = '0;
        wbm_err_o   = '0;
        wbm_dat_o   = '0;
        wbs_cyc_o   = '0;
        wbs_stb_o   = '0;
        wbs_we_o    = '0;
        wbs_adr_o   = '0;
        wbs_sel_o   = '0;
        wbs_dat_o   = '0;
        if (busy) begin
            wbm_stall_o[gnt_idx]            = m_stall;
            wbm_ack_o[gnt_idx]              = m_cyc & s_ack;
            wbm_err_o[gnt_idx]              = m_cyc & (s_err | err_pend_q);
            wbm_dat_o[int'(gnt_idx)*dw +: dw] = wbs_dat_i[int'(cur_s_q)*dw +: dw];
            for (int i = 0; i < nums; i++) begin
                wbs_cyc_o[i] = m_cyc & (cnt_nz ? (SW'(i) == cur_s_q) : ss[i]);
                if (ss[i]) begin
                    wbs_stb_o[i]                 = m_cyc & m_stb & !blocked;
                    wbs_we_o[i]                  = m_we;
                    wbs_adr_o[i*aw +: aw]        = m_adr;
                    wbs_sel_o[i*SELW +: SELW]    = m_sel;
                    wbs_dat_o[i*dw +: dw]        = m_dat;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_s_d    = cur_s_q;
        err_pend_d = err_pend_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) state_d = BUSY;
            end
            BUSY: begin
                if (!m_cyc) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                end else begin
                    if (accept && !resp)      cnt_d = cnt_q + CW'(1);
                    else if (resp && !accept) cnt_d = cnt_q - CW'(1);
                    if (accept && hit)        cur_s_d = sel_s;
                    if (err_pend_q)           err_pend_d = 1'b0;
                    if (accept && !hit)       err_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_s_q    <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_s_q    <= cur_s_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_wb_interconnect_sharedbus_rr.sv
// tb/tb_wb_interconnect_sharedbus_rr.sv - scoreboard bench for the round-robin shared bus
module tb_wb_interconnect_sharedbus_rr;
    import wb_ic_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  m_cyc, m_stb, m_we;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [63:0] wbm_adr, wbm_dati, wbm_dato;
    logic [7:0]  wbm_sel;
    logic [1:0]  wbm_ack, wbm_err, wbm_stall;
    logic [1:0]  s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
    logic [63:0] s_adr, s_dato, s_dati;
    logic [7:0]  s_sel;

    assign wbm_adr  = {m_adr[1], m_adr[0]};
    assign wbm_dati = {m_dat[1], m_dat[0]};
    assign wbm_sel  = 8'hFF;
    assign s_err    = 2'b00;
    assign s_stall  = 2'b00;

    wb_interconnect_sharedbus_rr #(
        .numm(2), .nums(2), .aw(32), .dw(32), .max_outst(4),
        .base_addr({32'h0000_1000, 32'h0000_0000}),
        .size({32'h0000_1000, 32'h0000_1000})
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we), .wbm_adr_i(wbm_adr),
        .wbm_sel_i(wbm_sel), .wbm_dat_i(wbm_dati), .wbm_dat_o(wbm_dato),
        .wbm_ack_o(wbm_ack), .wbm_err_o(wbm_err), .wbm_stall_o(wbm_stall),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we), .wbs_adr_o(s_adr),
        .wbs_sel_o(s_sel), .wbs_dat_o(s_dato), .wbs_dat_i(s_dati),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_stall_i(s_stall)
    );

    // Slave models: fixed ack latency, read data is a tag byte over the low address bits.
    int          lat = 1;
    logic [7:0]  apipe [2];
    logic [31:0] dpipe [2][8];

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) apipe[s] <= '0;
            else     apipe[s] <= {apipe[s][6:0], s_cyc[s] & s_stb[s] & !s_stall[s]};
            for (int k = 7; k > 0; k--) dpipe[s][k] <= dpipe[s][k-1];
            dpipe[s][0] <= s_we[s] ? 32'h0 : {(s == 0) ? 8'hA0 : 8'hB0, s_adr[s*32 +: 24]};
        end
    end

    always_comb begin
        s_ack  = '0;
        s_dati = '0;
        for (int s = 0; s < 2; s++) begin
            s_ack[s]          = apipe[s][lat-1];
            s_dati[s*32 +: 32] = dpipe[s][lat-1];
        end
    end

    int   checks = 0, errors = 0, cyc_n = 0;
    exp_t q0[$], q1[$];
    int   glog[$];
    int   ack_cnt [2] = '{0, 0};
    int   acc_cyc [2] = '{0, 0};
    int   err_cyc [2] = '{-1, -1};
    int   stb_cnt = 0, s1_stb_cyc = -1, s0_ack_cyc = -1;
    int   acc_run = 0, first_stall_acc = -1;

    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: every forwarded response is popped from its master's queue and compared.
    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                if (wbm_ack[m] || wbm_err[m]) begin
                    exp_t e;
                    ack_cnt[m]++;
                    if (wbm_err[m]) err_cyc[m] = cyc_n;
                    checks++;
                    if (qsize(m) == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp m%0d: got ack=%0b err=%0b expected none", m, wbm_ack[m], wbm_err[m]);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        if (wbm_err[m] !== e.err || (!e.err && wbm_dato[m*32 +: 32] !== e.dat)) begin
                            errors++;
                            $display("FAIL resp m%0d: got err=%0b dat=%0h expected err=%0b dat=%0h",
                                     m, wbm_err[m], wbm_dato[m*32 +: 32], e.err, e.dat);
                        end
                    end
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (s_stb[s] && s_we[s]) begin
                    check("wr_data", {32'h0, s_dato[s*32 +: 32]}, {32'h0, 32'hD000_0000 | s_adr[s*32 +: 32]});
                    check("wr_sel", {60'h0, s_sel[s*4 +: 4]}, 64'hF);
                end
            end
            if (s_stb != 2'b00) stb_cnt++;
            if (s_stb[1] && s1_stb_cyc < 0) s1_stb_cyc = cyc_n;
            if (s_ack[0] && wbm_ack[0]) s0_ack_cyc = cyc_n;
        end
    end

    task automatic issue(input int m, input logic [31:0] adr, input logic we,
                         input logic [31:0] exp_dat, input logic exp_err, input bit push);
        bit ok;
        ok = 0;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_adr[m] = adr;
        m_we[m]  = we;
        m_dat[m] = 32'hD000_0000 | adr;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!wbm_stall[m]) begin
                ok = 1;
                break;
            end
            if (acc_run > 0 && first_stall_acc < 0) first_stall_acc = acc_run;
        end
        if (ok) begin
            acc_cyc[m] = cyc_n;
            acc_run++;
            glog.push_back(m);
            if (push) begin
                if (m == 0) q0.push_back('{exp_err, exp_dat});
                else        q1.push_back('{exp_err, exp_dat});
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout m%0d: got stall=1 expected accept", m);
        end
        @(posedge clk);
        #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic wait_drain(input int m);
        for (int i = 0; i < 300; i++) begin
            if (qsize(m) == 0) break;
            @(negedge clk);
        end
        if (qsize(m) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout m%0d: got %0d pending expected 0", m, qsize(m));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rr_master(input int m);
        for (int r = 0; r < 2; r++) begin
            m_cyc[m] = 1'b1;
            if (m == 0) issue(0, 32'h0000_0010 + 32'(r*4), 1'b0, 32'hA000_0010 + 32'(r*4), 1'b0, 1);
            else        issue(1, 32'h0000_1020 + 32'(r*4), 1'b0, 32'hB000_1020 + 32'(r*4), 1'b0, 1);
            wait_drain(m);
            m_cyc[m] = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ack0, drop_c, stb0;
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '{32'h0, 32'h0};
        m_dat = '{32'h0, 32'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {62'h0, wbm_stall}, 64'h3);
        check("rst_ack_err", {60'h0, wbm_ack, wbm_err}, 64'h0);
        check("rst_mdat", wbm_dato, 64'h0);
        check("rst_scyc_stb", {60'h0, s_cyc, s_stb}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_state", {63'h0, dut.state_q}, {63'h0, IDLE});
        check("idle_stall", {62'h0, wbm_stall}, 64'h3);

        // Round robin: both masters request, one transfer per tenure.
        lat = 1;
        glog.delete();
        fork
            rr_master(0);
            rr_master(1);
        join
        check("rr_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            check("rr_g0", 64'(glog[0]), 64'd0);
            check("rr_g1", 64'(glog[1]), 64'd1);
            check("rr_g2", 64'(glog[2]), 64'd0);
            check("rr_g3", 64'(glog[3]), 64'd1);
        end

        // Pipeline: six reads, stall after four outstanding.
        lat = 4;
        acc_run = 0;
        first_stall_acc = -1;
        m_cyc[0] = 1'b1;
        for (int i = 0; i < 6; i++)
            issue(0, 32'h0000_0100 + 32'(i*4), 1'b0, 32'hA000_0100 + 32'(i*4), 1'b0, 1);
        wait_drain(0);
        check("pipe_stall_after", 64'(first_stall_acc), 64'd4);
        check("pipe_cnt_zero", 64'(dut.cnt_q), 64'd0);
        m_cyc[0] = 1'b0;
        @(posedge clk);
        #1;

        // Slave switch: write slave 0, then read slave 1.
        lat = 2;
        s1_stb_cyc = -1;
        s0_ack_cyc = -1;
        m_cyc[0] = 1'b1;
        issue(0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1);
        issue(0, 32'h0000_1004, 1'b0, 32'hB000_1004, 1'b0, 1);
        wait_drain(0);
        check("switch_stb_after_ack", 64'(s1_stb_cyc), 64'(s0_ack_cyc + 1));
        m_cyc[0] = 1'b0;
        @(posedge clk);
        #1;

        // Unmapped address.
        lat = 1;
        stb0 = stb_cnt;
        m_cyc[0] = 1'b1;
        issue(0, 32'h0000_8000, 1'b0, 32'h0, 1'b1, 1);
        wait_drain(0);
        check("unmapped_err_lat", 64'(err_cyc[0]), 64'(acc_cyc[0] + 1));
        check("unmapped_no_stb", 64'(stb_cnt), 64'(stb0));
        check("unmapped_cnt_zero", 64'(dut.cnt_q), 64'd0);
        m_cyc[0] = 1'b0;
        @(posedge clk);
        #1;

        // Abort with two outstanding; master 1 waits for the bus.
        lat = 3;
        ack0 = ack_cnt[0];
        m_cyc[0] = 1'b1;
        issue(0, 32'h0000_0200, 1'b0, 32'h0, 1'b0, 0);
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_adr[1] = 32'h0000_1008;
        m_we[1]  = 1'b0;
        issue(0, 32'h0000_0204, 1'b0, 32'h0, 1'b0, 0);
        m_cyc[0] = 1'b0;
        drop_c = cyc_n;
        issue(1, 32'h0000_1008, 1'b0, 32'hB000_1008, 1'b0, 1);
        check("abort_regrant", 64'(acc_cyc[1]), 64'(drop_c + 2));
        wait_drain(1);
        m_cyc[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_ack", 64'(ack_cnt[0]), 64'(ack0));
        check("end_queues_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
